// File: rtl/vram_slot_arbiter_pkg.sv
// vram_slot_arbiter_pkg: owner encoding, default widths and slot-type constant
package vram_slot_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic SLOT_VID = 1'b1;
    typedef enum logic [2:0] {OWN_NONE, OWN_VID, OWN_CPU0, OWN_CPU1, OWN_POST} owner_e;
endpackage

// File: rtl/vram_slot_post_buffer.sv
// vram_slot_post_buffer: one-entry posted write buffer, loaded on accept, cleared on drain
module vram_slot_post_buffer #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= load_i | (valid_q & ~drain_i);
            if (load_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end
    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
endmodule

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: time-slot arbiter sharing one video RAM between video fetch and two CPUs
// VRAM_SLOT_ARBITER_POST_WRITE_EN adds a one-entry posted CPU write buffer
module vram_slot_arbiter
    import vram_slot_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK_6M,
    input  logic                  rst,
    input  logic                  CLK_2H,
    input  logic                  nVBLK,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_valid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    input  logic                  cpu0_req,
    input  logic                  cpu0_we,
    input  logic [ADDR_WIDTH-1:0] cpu0_addr,
    input  logic [DATA_WIDTH-1:0] cpu0_wdata,
    output logic                  cpu0_ack,
    output logic [DATA_WIDTH-1:0] cpu0_rdata,
    input  logic                  cpu1_req,
    input  logic                  cpu1_we,
    input  logic [ADDR_WIDTH-1:0] cpu1_addr,
    input  logic [DATA_WIDTH-1:0] cpu1_wdata,
    output logic                  cpu1_ack,
    output logic [DATA_WIDTH-1:0] cpu1_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    owner_e                own_q, own_d, last_q, last_d, pacc_q, pacc_d;
    logic                  vid_slot, e0, e1, r0, r1, pick1, drain, we_d;
    logic                  ram_cs_q, ram_we_q, vid_valid_q, cpu0_ack_q, cpu1_ack_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q, addr_d, pa;
    logic [DATA_WIDTH-1:0] ram_wdata_q, wdata_d, pd, vid_rdata_q, cpu0_rdata_q, cpu1_rdata_q;

    assign vid_slot = (CLK_2H == SLOT_VID) & nVBLK;

`ifdef VRAM_SLOT_ARBITER_POST_WRITE_EN
    logic pv, w0, w1;
    // a posted write keeps its requester in flight until its ack, like a RAM grant
    assign e0 = cpu0_req & (own_q != OWN_CPU0) & (pacc_q != OWN_CPU0);
    assign e1 = cpu1_req & (own_q != OWN_CPU1) & (pacc_q != OWN_CPU1);
    assign w0 = e0 & cpu0_we & ~pv;
    assign w1 = e1 & cpu1_we & ~pv;
    assign r0 = e0 & ~cpu0_we & ~pv;
    assign r1 = e1 & ~cpu1_we & ~pv;
    assign pacc_d = (w0 & ~(w1 & last_q == OWN_CPU0)) ? OWN_CPU0 : w1 ? OWN_CPU1 : OWN_NONE;
    assign drain = ~vid_slot & pv;
    vram_slot_post_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_post (
        .clk_i(CLK_6M), .rst_i(rst), .load_i(pacc_d != OWN_NONE), .drain_i(drain),
        .addr_i(pacc_d == OWN_CPU1 ? cpu1_addr : cpu0_addr),
        .data_i(pacc_d == OWN_CPU1 ? cpu1_wdata : cpu0_wdata),
        .valid_o(pv), .addr_o(pa), .data_o(pd)
    );
`else
    assign e0 = cpu0_req & (own_q != OWN_CPU0);
    assign e1 = cpu1_req & (own_q != OWN_CPU1);
    assign r0 = e0;
    assign r1 = e1;
    assign pacc_d = OWN_NONE;
    assign drain = 1'b0;
    assign pa = '0;
    assign pd = '0;
`endif

    assign pick1   = r1 & (~r0 | last_q == OWN_CPU0);
    assign own_d   = vid_slot ? (vid_req ? OWN_VID : OWN_NONE) : drain ? OWN_POST :
                     pick1 ? OWN_CPU1 : r0 ? OWN_CPU0 : OWN_NONE;
    assign last_d  = (own_d == OWN_CPU0 || own_d == OWN_CPU1) ? own_d :
                     (pacc_d != OWN_NONE) ? pacc_d : last_q;
    assign we_d    = (own_d == OWN_POST) | (own_d == OWN_CPU0 & cpu0_we) | (own_d == OWN_CPU1 & cpu1_we);
    assign addr_d  = own_d == OWN_VID ? vid_addr : own_d == OWN_CPU1 ? cpu1_addr :
                     own_d == OWN_POST ? pa : cpu0_addr;
    assign wdata_d = own_d == OWN_POST ? pd : own_d == OWN_CPU1 ? cpu1_wdata : cpu0_wdata;

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            own_q        <= OWN_NONE;
            pacc_q       <= OWN_NONE;
            last_q       <= OWN_CPU1;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            vid_valid_q  <= 1'b0;
            cpu0_ack_q   <= 1'b0;
            cpu1_ack_q   <= 1'b0;
            vid_rdata_q  <= '0;
            cpu0_rdata_q <= '0;
            cpu1_rdata_q <= '0;
        end else begin
            own_q       <= own_d;
            pacc_q      <= pacc_d;
            last_q      <= last_d;
            ram_cs_q    <= own_d != OWN_NONE;
            ram_we_q    <= we_d;
            if (own_d != OWN_NONE) begin
                ram_addr_q  <= addr_d;
                ram_wdata_q <= wdata_d;
            end
            vid_valid_q <= own_q == OWN_VID;
            cpu0_ack_q  <= (own_q == OWN_CPU0) | (pacc_q == OWN_CPU0);
            cpu1_ack_q  <= (own_q == OWN_CPU1) | (pacc_q == OWN_CPU1);
            if (own_q == OWN_VID) vid_rdata_q <= ram_rdata;
            if (own_q == OWN_CPU0 && !ram_we_q) cpu0_rdata_q <= ram_rdata;
            if (own_q == OWN_CPU1 && !ram_we_q) cpu1_rdata_q <= ram_rdata;
        end
    end

    assign ram_cs     = ram_cs_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign vid_valid  = vid_valid_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu0_ack   = cpu0_ack_q;
    assign cpu0_rdata = cpu0_rdata_q;
    assign cpu1_ack   = cpu1_ack_q;
    assign cpu1_rdata = cpu1_rdata_q;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed self-checking bench with a behavioural RAM
// unwritten RAM words read back as addr[7:0] ^ 8'h5A
module tb_vram_slot_arbiter;
    logic        CLK_6M = 1'b0, rst = 1'b1, CLK_2H = 1'b0, nVBLK = 1'b1;
    logic        vid_req = 1'b0, vid_valid;
    logic [12:0] vid_addr = '0;
    logic [7:0]  vid_rdata;
    logic        cpu0_req = 1'b0, cpu0_we = 1'b0, cpu0_ack;
    logic [12:0] cpu0_addr = '0;
    logic [7:0]  cpu0_wdata = '0, cpu0_rdata;
    logic        cpu1_req = 1'b0, cpu1_we = 1'b0, cpu1_ack;
    logic [12:0] cpu1_addr = '0;
    logic [7:0]  cpu1_wdata = '0, cpu1_rdata;
    logic        ram_cs, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    bit   [7:0]  mem [8192];
    bit          wrt [8192];
    bit          hold_2h = 1'b0;
    int          nchk = 0, nerr = 0;

    vram_slot_arbiter dut (
        .CLK_6M(CLK_6M), .rst(rst), .CLK_2H(CLK_2H), .nVBLK(nVBLK),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .cpu0_req(cpu0_req), .cpu0_we(cpu0_we), .cpu0_addr(cpu0_addr), .cpu0_wdata(cpu0_wdata),
        .cpu0_ack(cpu0_ack), .cpu0_rdata(cpu0_rdata),
        .cpu1_req(cpu1_req), .cpu1_we(cpu1_we), .cpu1_addr(cpu1_addr), .cpu1_wdata(cpu1_wdata),
        .cpu1_ack(cpu1_ack), .cpu1_rdata(cpu1_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial forever #5 CLK_6M = ~CLK_6M;
    always @(negedge CLK_6M) CLK_2H = hold_2h | ~CLK_2H;
    always @(posedge CLK_6M) if (ram_cs && ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wrt[ram_addr] <= 1'b1;
    end
    assign ram_rdata = wrt[ram_addr] ? mem[ram_addr] : (ram_addr[7:0] ^ 8'h5A);

    task automatic step;
        @(posedge CLK_6M);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        nchk++; if (ram_cs !== 1'b0) begin nerr++; $display("FAIL reset_cs: got %b want 0", ram_cs); end
        nchk++; if (ram_we !== 1'b0) begin nerr++; $display("FAIL reset_we: got %b want 0", ram_we); end
        nchk++; if (ram_addr !== 13'h0) begin nerr++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
        nchk++; if (ram_wdata !== 8'h0) begin nerr++; $display("FAIL reset_wdata: got %h want 0", ram_wdata); end
        nchk++; if ({vid_valid, cpu0_ack, cpu1_ack} !== 3'b000) begin
            nerr++; $display("FAIL reset_acks: got %b want 000", {vid_valid, cpu0_ack, cpu1_ack}); end
        nchk++; if ({vid_rdata, cpu0_rdata, cpu1_rdata} !== 24'h0) begin
            nerr++; $display("FAIL reset_rdata: got %h want 0", {vid_rdata, cpu0_rdata, cpu1_rdata}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_video;
        logic prev_h = 1'b0;
        nVBLK = 1'b1; vid_req = 1'b1; vid_addr = 13'h0123;
        for (int i = 0; i < 8; i++) begin
            step();
            nchk++; if (ram_cs !== CLK_2H) begin nerr++; $display("FAIL vid_cs[%0d]: got %b want %b", i, ram_cs, CLK_2H); end
            if (CLK_2H) begin
                nchk++; if ({ram_we, ram_addr} !== {1'b0, 13'h0123}) begin
                    nerr++; $display("FAIL vid_addr[%0d]: got we=%b addr=%h want we=0 addr=0123", i, ram_we, ram_addr); end
            end
            nchk++; if (vid_valid !== prev_h) begin nerr++; $display("FAIL vid_valid[%0d]: got %b want %b", i, vid_valid, prev_h); end
            if (prev_h) begin
                nchk++; if (vid_rdata !== 8'h79) begin nerr++; $display("FAIL vid_rdata[%0d]: got %h want 79", i, vid_rdata); end
            end
            nchk++; if ({cpu0_ack, cpu1_ack} !== 2'b00) begin nerr++; $display("FAIL vid_cpuack[%0d]: got %b want 00", i, {cpu0_ack, cpu1_ack}); end
            prev_h = CLK_2H;
        end
        vid_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_cpu_pair;
        int g0 = -1, g1 = -1, a0 = 0, a1 = 0;
        cpu0_we = 1'b0; cpu0_addr = 13'h0010; cpu0_req = 1'b1;
        cpu1_we = 1'b0; cpu1_addr = 13'h0020; cpu1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ram_cs) begin
                nchk++; if (CLK_2H !== 1'b0) begin nerr++; $display("FAIL pair_slot[%0d]: got CLK_2H=%b want 0", i, CLK_2H); end
                if (ram_addr == 13'h0010) g0 = i;
                if (ram_addr == 13'h0020) g1 = i;
            end
            if (cpu0_ack) begin
                a0++; cpu0_req = 1'b0;
                nchk++; if (cpu0_rdata !== 8'h4A) begin nerr++; $display("FAIL pair_rdata0: got %h want 4a", cpu0_rdata); end
            end
            if (cpu1_ack) begin
                a1++; cpu1_req = 1'b0;
                nchk++; if (cpu1_rdata !== 8'h7A) begin nerr++; $display("FAIL pair_rdata1: got %h want 7a", cpu1_rdata); end
            end
        end
        nchk++; if (a0 !== 1) begin nerr++; $display("FAIL pair_ack0_count: got %0d want 1", a0); end
        nchk++; if (a1 !== 1) begin nerr++; $display("FAIL pair_ack1_count: got %0d want 1", a1); end
        nchk++; if (g0 < 0 || g1 !== g0 + 2) begin nerr++; $display("FAIL pair_order: got g0=%0d g1=%0d want g1=g0+2", g0, g1); end
        cpu0_req = 1'b0; cpu1_req = 1'b0;
    endtask

    task automatic test_blank;
        nVBLK = 1'b0; vid_req = 1'b1; vid_addr = 13'h0123;
        cpu0_we = 1'b0; cpu0_addr = 13'h0010; cpu0_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            nchk++; if (ram_cs !== (i % 2 == 0)) begin nerr++; $display("FAIL blank_cs[%0d]: got %b want %b", i, ram_cs, i % 2 == 0); end
            if (ram_cs) begin
                nchk++; if (ram_addr !== 13'h0010) begin nerr++; $display("FAIL blank_addr[%0d]: got %h want 0010", i, ram_addr); end
            end
            nchk++; if (vid_valid !== 1'b0) begin nerr++; $display("FAIL blank_vid[%0d]: got %b want 0", i, vid_valid); end
            nchk++; if (cpu0_ack !== (i % 2 == 1)) begin nerr++; $display("FAIL blank_ack[%0d]: got %b want %b", i, cpu0_ack, i % 2 == 1); end
        end
        cpu0_req = 1'b0; vid_req = 1'b0; nVBLK = 1'b1;
        step();
        step();
    endtask

    task automatic test_write_read;
        int acks = 0;
        cpu1_we = 1'b1; cpu1_addr = 13'h1FFF; cpu1_wdata = 8'hA5; cpu1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu1_ack) begin acks++; cpu1_req = 1'b0; end
        end
        nchk++; if (acks !== 1) begin nerr++; $display("FAIL wr_ack_count: got %0d want 1", acks); end
        acks = 0;
        cpu1_we = 1'b0; cpu1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cpu1_ack) begin
                acks++; cpu1_req = 1'b0;
                nchk++; if (cpu1_rdata !== 8'hA5) begin nerr++; $display("FAIL rd_after_wr: got %h want a5", cpu1_rdata); end
            end
        end
        nchk++; if (acks !== 1) begin nerr++; $display("FAIL rd_ack_count: got %0d want 1", acks); end
        cpu1_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        nVBLK = 1'b0;
        cpu0_we = 1'b0; cpu0_addr = 13'h0020; cpu0_req = 1'b1;
        step();
        nchk++; if ({ram_cs, ram_addr} !== {1'b1, 13'h0020}) begin
            nerr++; $display("FAIL mid_grant: got cs=%b addr=%h want cs=1 addr=0020", ram_cs, ram_addr); end
        rst = 1'b1;
        step();
        nchk++; if ({ram_cs, ram_we, ram_addr, ram_wdata} !== 23'h0) begin
            nerr++; $display("FAIL mid_ram: got cs=%b we=%b addr=%h wd=%h want all 0", ram_cs, ram_we, ram_addr, ram_wdata); end
        nchk++; if ({vid_valid, cpu0_ack, cpu1_ack} !== 3'b000) begin
            nerr++; $display("FAIL mid_acks: got %b want 000", {vid_valid, cpu0_ack, cpu1_ack}); end
        nchk++; if ({vid_rdata, cpu0_rdata, cpu1_rdata} !== 24'h0) begin
            nerr++; $display("FAIL mid_rdata: got %h want 0", {vid_rdata, cpu0_rdata, cpu1_rdata}); end
        rst = 1'b0; cpu0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nchk++; if ({ram_cs, cpu0_ack} !== 2'b00) begin nerr++; $display("FAIL mid_after[%0d]: got cs/ack=%b want 00", i, {ram_cs, cpu0_ack}); end
        end
        nVBLK = 1'b1;
    endtask

`ifdef VRAM_SLOT_ARBITER_POST_WRITE_EN
    task automatic test_post;
        int acks = 0;
        bit drained = 1'b0;
        hold_2h = 1'b1; nVBLK = 1'b1; vid_req = 1'b1; vid_addr = 13'h0123;
        step();
        step();
        cpu0_we = 1'b1; cpu0_addr = 13'h0040; cpu0_wdata = 8'h3C; cpu0_req = 1'b1;
        step();
        nchk++; if ({cpu0_ack, ram_we} !== 2'b00) begin nerr++; $display("FAIL post_accept: got ack/we=%b want 00", {cpu0_ack, ram_we}); end
        step();
        nchk++; if (cpu0_ack !== 1'b1) begin nerr++; $display("FAIL post_ack: got %b want 1", cpu0_ack); end
        cpu0_req = 1'b0;
        cpu1_we = 1'b0; cpu1_addr = 13'h0040; cpu1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            nchk++; if ({cpu1_ack, ram_we} !== 2'b00) begin nerr++; $display("FAIL post_stall[%0d]: got ack/we=%b want 00", i, {cpu1_ack, ram_we}); end
        end
        hold_2h = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ram_cs && ram_we && ram_addr == 13'h0040 && ram_wdata == 8'h3C) drained = 1'b1;
            if (cpu1_ack) begin
                acks++; cpu1_req = 1'b0;
                nchk++; if ({drained, cpu1_rdata} !== {1'b1, 8'h3C}) begin
                    nerr++; $display("FAIL post_read: got drained=%b rdata=%h want drained=1 rdata=3c", drained, cpu1_rdata); end
            end
        end
        nchk++; if (acks !== 1) begin nerr++; $display("FAIL post_read_count: got %0d want 1", acks); end
        cpu1_req = 1'b0; vid_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_video();
        test_cpu_pair();
        test_blank();
        test_write_read();
        test_reset_mid();
`ifdef VRAM_SLOT_ARBITER_POST_WRITE_EN
        test_post();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
